// File: rtl/bert_pkg.sv
// ---------------------------------------------------------------------------
// bert_pkg
// Definitions shared by the bit-error-rate test blocks: the PRBS generator,
// the error injector and the PRBS checker.
//
// Contents:
//   PRBS_W        width of the PRBS history / LFSR register (8)
//   TAP_A/B/C     history taps feeding the predicted bit (6, 5, 0)
//   CNT_W         width of the statistics counters (32)
//   bert_state_t  checker synchronisation state (HUNT / LOCKED)
//   prbs_predict  next bit predicted from a history register
//   prbs_shift    history update, new bit enters at bit 0
//   sat_inc       saturating increment for statistics counters
// ---------------------------------------------------------------------------
package bert_pkg;

    localparam int PRBS_W = 8;
    localparam int TAP_A  = 6;
    localparam int TAP_B  = 5;
    localparam int TAP_C  = 0;
    localparam int CNT_W  = 32;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } bert_state_t;

    // Bit the PRBS source will emit next, given its last PRBS_W bits
    // (bit 0 is the most recent one).
    function automatic logic prbs_predict(input logic [PRBS_W-1:0] hist);
        return hist[TAP_A] ^ hist[TAP_B] ^ hist[TAP_C];
    endfunction

    // Oldest bit drops out of the top, newest enters at bit 0.
    function automatic logic [PRBS_W-1:0] prbs_shift(input logic [PRBS_W-1:0] hist,
                                                     input logic              new_bit);
        return {hist[PRBS_W-2:0], new_bit};
    endfunction

    // Counters stick at all-ones instead of wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == {CNT_W{1'b1}}) ? value : value + CNT_ONE;
    endfunction

endpackage

// File: rtl/loss_monitor.sv
// ---------------------------------------------------------------------------
// loss_monitor
// Loss-of-lock detector for the PRBS checker. While the checker is locked it
// splits the stream of valid bits into consecutive windows of LOSS_WIN bits
// and counts mismatches inside the current window. When the errors already
// seen in the window plus the error on the current bit reach LOSS_THR,
// lose_lock is raised combinationally for that bit so the checker can drop
// back to HUNT on the same clock edge.
//
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous active-low reset
//   valid      current cycle carries a received bit
//   locked     checker is currently in the LOCKED state
//   err        current valid bit mismatched the local LFSR
//   lose_lock  this bit pushes the window error count to the threshold
// ---------------------------------------------------------------------------
module loss_monitor #(
    parameter int LOSS_WIN = 64,
    parameter int LOSS_THR = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic valid,
    input  logic locked,
    input  logic err,
    output logic lose_lock
);

    localparam int WIN_W = (LOSS_WIN > 1) ? $clog2(LOSS_WIN) : 1;
    localparam int ERR_W = $clog2(LOSS_THR + 1);

    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(LOSS_WIN - 1);
    localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);
    localparam logic [ERR_W:0]   ERR_THR  = (ERR_W + 1)'(LOSS_THR);

    logic [WIN_W-1:0] win_cnt_reg, win_cnt_next;
    logic [ERR_W-1:0] win_err_reg, win_err_next;
    logic [ERR_W:0]   err_sum;
    logic             active;

    assign active  = valid && locked;
    // One spare bit so the sum can never wrap before the compare.
    assign err_sum = {1'b0, win_err_reg} + {{ERR_W{1'b0}}, err};

    always_comb begin
        lose_lock    = active && (err_sum >= ERR_THR);
        win_cnt_next = win_cnt_reg;
        win_err_next = win_err_reg;
        if (!locked) begin
            // Window always starts empty on the next lock.
            win_cnt_next = '0;
            win_err_next = '0;
        end else if (active) begin
            // Losing lock and hitting the window end on the same bit both
            // clear the window; the loss itself is reported via lose_lock.
            if (lose_lock || (win_cnt_reg == WIN_LAST)) begin
                win_cnt_next = '0;
                win_err_next = '0;
            end else begin
                win_cnt_next = win_cnt_reg + WIN_ONE;
                // err_sum is below the threshold here, so it fits ERR_W.
                win_err_next = err_sum[ERR_W-1:0];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            win_cnt_reg <= '0;
            win_err_reg <= '0;
        end else begin
            win_cnt_reg <= win_cnt_next;
            win_err_reg <= win_err_next;
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// ---------------------------------------------------------------------------
// prbs_checker
// Self-synchronising checker for the 8-bit PRBS stream (taps 6,5,0).
//
// HUNT   : received bits are shifted into a history register. After 8 fill
//          bits every further bit is compared with the bit predicted from
//          the history; LOCK_CNT consecutive correct predictions (with a
//          non-zero history) declare lock and seed the local LFSR.
// LOCKED : the local LFSR free-runs on its own predictions, so a corrupted
//          received bit never pollutes the reference. Each mismatch raises
//          err_pulse one cycle later and is counted. loss_monitor forces a
//          return to HUNT when a window accumulates LOSS_THR errors.
//
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous active-low reset
//   in_valid   in_bit carries a received PRBS bit this cycle
//   in_bit     received serial bit
//   clear      synchronous zeroing of bit_count and err_count
//   locked     checker is synchronised to the stream
//   err_pulse  one-cycle flag: previous valid bit mismatched while locked
//   bit_count  valid bits checked while locked (saturating)
//   err_count  mismatched bits while locked (saturating)
// ---------------------------------------------------------------------------
module prbs_checker
    import bert_pkg::*;
#(
    parameter int LOCK_CNT = 16,
    parameter int LOSS_WIN = 64,
    parameter int LOSS_THR = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] bit_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int FILL_W  = $clog2(PRBS_W + 1);
    localparam int MATCH_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT + 1) : 1;

    localparam logic [FILL_W-1:0]  FILL_DONE  = FILL_W'(PRBS_W);
    localparam logic [FILL_W-1:0]  FILL_ONE   = FILL_W'(1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
    localparam logic [MATCH_W-1:0] MATCH_ONE  = MATCH_W'(1);

    bert_state_t        state_reg, state_next;
    logic [PRBS_W-1:0]  hist_reg,  hist_next;
    logic [PRBS_W-1:0]  lfsr_reg,  lfsr_next;
    logic [FILL_W-1:0]  fill_reg,  fill_next;
    logic [MATCH_W-1:0] match_reg, match_next;
    logic               err_pulse_reg, err_pulse_next;

    logic is_locked;
    logic hunt_predict;
    logic lock_predict;
    logic lock_err;
    logic lose_lock;

    assign is_locked    = (state_reg == ST_LOCKED);
    assign hunt_predict = prbs_predict(hist_reg);
    assign lock_predict = prbs_predict(lfsr_reg);
    assign lock_err     = in_valid && is_locked && (in_bit != lock_predict);

    // -----------------------------------------------------------------------
    // Loss-of-lock window
    // -----------------------------------------------------------------------
    loss_monitor #(
        .LOSS_WIN (LOSS_WIN),
        .LOSS_THR (LOSS_THR)
    ) u_loss_monitor (
        .clock     (clock),
        .reset     (reset),
        .valid     (in_valid),
        .locked    (is_locked),
        .err       (lock_err),
        .lose_lock (lose_lock)
    );

    // -----------------------------------------------------------------------
    // Synchronisation FSM: next state and datapath
    // -----------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        hist_next      = hist_reg;
        lfsr_next      = lfsr_reg;
        fill_next      = fill_reg;
        match_next     = match_reg;
        err_pulse_next = lock_err;

        if (in_valid) begin
            case (state_reg)
                ST_HUNT: begin
                    hist_next = prbs_shift(hist_reg, in_bit);
                    if (fill_reg != FILL_DONE) begin
                        fill_next = fill_reg + FILL_ONE;
                    end else if (hist_reg == '0) begin
                        // An all-zero history predicts zero forever, which
                        // an idle or dead link would satisfy trivially.
                        match_next = '0;
                    end else if (in_bit == hunt_predict) begin
                        if (match_reg == MATCH_LAST) begin
                            state_next = ST_LOCKED;
                            lfsr_next  = hist_next;
                            match_next = '0;
                        end else begin
                            match_next = match_reg + MATCH_ONE;
                        end
                    end else begin
                        match_next = '0;
                    end
                end

                ST_LOCKED: begin
                    // Reference advances on its own prediction only.
                    lfsr_next = prbs_shift(lfsr_reg, lock_predict);
                    if (lose_lock) begin
                        state_next = ST_HUNT;
                        fill_next  = '0;
                        match_next = '0;
                    end
                end

                default: begin
                    state_next = ST_HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_HUNT;
            hist_reg      <= '0;
            lfsr_reg      <= '0;
            fill_reg      <= '0;
            match_reg     <= '0;
            err_pulse_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            hist_reg      <= hist_next;
            lfsr_reg      <= lfsr_next;
            fill_reg      <= fill_next;
            match_reg     <= match_next;
            err_pulse_reg <= err_pulse_next;
        end
    end

    // -----------------------------------------------------------------------
    // Statistics counters: index 0 counts checked bits, index 1 errors.
    // clear wins over a same-cycle increment.
    // -----------------------------------------------------------------------
    logic [1:0]       stat_inc;
    logic [CNT_W-1:0] stat_count [2];

    assign stat_inc = {lock_err, in_valid && is_locked};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_stat
            logic [CNT_W-1:0] count_reg, count_next;

            always_comb begin
                count_next = count_reg;
                if (clear) begin
                    count_next = '0;
                end else if (stat_inc[gi]) begin
                    count_next = sat_inc(count_reg);
                end
            end

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    count_reg <= '0;
                end else begin
                    count_reg <= count_next;
                end
            end

            assign stat_count[gi] = count_reg;
        end
    endgenerate

    assign locked    = is_locked;
    assign err_pulse = err_pulse_reg;
    assign bit_count = stat_count[0];
    assign err_count = stat_count[1];

endmodule

// File: tb/tb_prbs_checker.sv
// ---------------------------------------------------------------------------
// tb_prbs_checker
// Directed testbench for prbs_checker with default parameters
// (LOCK_CNT=16, LOSS_WIN=64, LOSS_THR=8). A reference PRBS source
// (b = h[6]^h[5]^h[0], h <= {h[6:0], b}, seed 8'h0F) feeds the checker;
// selected bits are inverted to inject errors.
// ---------------------------------------------------------------------------
module tb_prbs_checker;

    logic        clock    = 1'b0;
    logic        reset    = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_bit   = 1'b0;
    logic        clear    = 1'b0;
    logic        locked;
    logic        err_pulse;
    logic [31:0] bit_count;
    logic [31:0] err_count;

    int checks   = 0;
    int failures = 0;

    logic [7:0] gen_h = 8'h0F;

    prbs_checker dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .clear     (clear),
        .locked    (locked),
        .err_pulse (err_pulse),
        .bit_count (bit_count),
        .err_count (err_count)
    );

    always #5 clock = ~clock;

    // Reference generator: next bit of the clean stream.
    task automatic gen_next(output logic b);
        b     = gen_h[6] ^ gen_h[5] ^ gen_h[0];
        gen_h = {gen_h[6:0], b};
    endtask

    // One valid bit; outputs are sampled 1 time unit after the edge.
    task automatic send_bit(input logic b, input logic clr);
        in_valid = 1'b1;
        in_bit   = b;
        clear    = clr;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic send_gen(input logic flip);
        logic b;
        gen_next(b);
        send_bit(b ^ flip, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        gen_h = 8'h0F;
    endtask

    task automatic lock_up();
        apply_reset();
        for (int i = 0; i < 24; i++) send_gen(1'b0);
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL lock_up locked=%0b expected=1", locked);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(posedge clock);
        #1;
        checks += 4;
        if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%0b exp=0", locked); end
        if (err_pulse !== 1'b0) begin failures++; $display("FAIL reset_err_pulse got=%0b exp=0", err_pulse); end
        if (bit_count !== 32'd0) begin failures++; $display("FAIL reset_bit_count got=%0d exp=0", bit_count); end
        if (err_count !== 32'd0) begin failures++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
        $display("test_reset done");
    endtask

    task automatic test_clean_lock();
        int pulses = 0;
        apply_reset();
        for (int i = 0; i < 23; i++) send_gen(1'b0);
        checks++;
        if (locked !== 1'b0) begin failures++; $display("FAIL clean_early_lock got=%0b exp=0", locked); end
        send_gen(1'b0);
        checks += 2;
        if (locked !== 1'b1) begin failures++; $display("FAIL clean_lock_at_24 got=%0b exp=1", locked); end
        if (bit_count !== 32'd0) begin failures++; $display("FAIL clean_bits_at_lock got=%0d exp=0", bit_count); end
        for (int i = 0; i < 50; i++) begin
            send_gen(1'b0);
            if (err_pulse === 1'b1) pulses++;
        end
        checks += 3;
        if (bit_count !== 32'd50) begin failures++; $display("FAIL clean_bit_count got=%0d exp=50", bit_count); end
        if (err_count !== 32'd0) begin failures++; $display("FAIL clean_err_count got=%0d exp=0", err_count); end
        if (pulses != 0) begin failures++; $display("FAIL clean_err_pulses got=%0d exp=0", pulses); end
        $display("test_clean_lock done bit_count=%0d", bit_count);
    endtask

    task automatic test_gapped();
        apply_reset();
        for (int i = 0; i < 23; i++) begin
            send_gen(1'b0);
            idle(2);
        end
        checks++;
        if (locked !== 1'b0) begin failures++; $display("FAIL gap_early_lock got=%0b exp=0", locked); end
        send_gen(1'b0);
        checks++;
        if (locked !== 1'b1) begin failures++; $display("FAIL gap_lock_at_24 got=%0b exp=1", locked); end
        idle(2);
        checks += 2;
        if (locked !== 1'b1) begin failures++; $display("FAIL gap_lock_hold got=%0b exp=1", locked); end
        if (bit_count !== 32'd0) begin failures++; $display("FAIL gap_idle_count got=%0d exp=0", bit_count); end
        for (int i = 0; i < 50; i++) begin
            send_gen(1'b0);
            idle(2);
        end
        checks += 2;
        if (bit_count !== 32'd50) begin failures++; $display("FAIL gap_bit_count got=%0d exp=50", bit_count); end
        if (err_count !== 32'd0) begin failures++; $display("FAIL gap_err_count got=%0d exp=0", err_count); end
        $display("test_gapped done bit_count=%0d", bit_count);
    endtask

    task automatic test_sparse_errors();
        int   bad_pulse = 0;
        int   unlocks   = 0;
        logic flip;
        lock_up();
        for (int i = 0; i < 1000; i++) begin
            flip = ((i % 100) == 99);
            send_gen(flip);
            if (err_pulse !== flip) bad_pulse++;
            if (locked !== 1'b1) unlocks++;
        end
        checks += 4;
        if (bad_pulse != 0) begin failures++; $display("FAIL sparse_err_pulse wrong_cycles=%0d exp=0", bad_pulse); end
        if (unlocks != 0) begin failures++; $display("FAIL sparse_locked unlocked_cycles=%0d exp=0", unlocks); end
        if (err_count !== 32'd10) begin failures++; $display("FAIL sparse_err_count got=%0d exp=10", err_count); end
        if (bit_count !== 32'd1000) begin failures++; $display("FAIL sparse_bit_count got=%0d exp=1000", bit_count); end
        idle(1);
        checks += 2;
        if (err_pulse !== 1'b0) begin failures++; $display("FAIL sparse_pulse_idle_clear got=%0b exp=0", err_pulse); end
        if (err_count !== 32'd10) begin failures++; $display("FAIL sparse_idle_hold got=%0d exp=10", err_count); end
        $display("test_sparse_errors done err_count=%0d", err_count);
    endtask

    task automatic test_burst();
        lock_up();
        for (int i = 0; i < 8; i++) send_gen(1'b0);
        for (int i = 0; i < 7; i++) send_gen(1'b1);
        checks += 2;
        if (locked !== 1'b1) begin failures++; $display("FAIL burst_locked_after_7 got=%0b exp=1", locked); end
        if (err_count !== 32'd7) begin failures++; $display("FAIL burst_err_after_7 got=%0d exp=7", err_count); end
        send_gen(1'b1);
        checks += 4;
        if (locked !== 1'b0) begin failures++; $display("FAIL burst_loss_on_8 got=%0b exp=0", locked); end
        if (err_count !== 32'd8) begin failures++; $display("FAIL burst_err_count got=%0d exp=8", err_count); end
        if (bit_count !== 32'd16) begin failures++; $display("FAIL burst_bit_count got=%0d exp=16", bit_count); end
        if (err_pulse !== 1'b1) begin failures++; $display("FAIL burst_err_pulse got=%0b exp=1", err_pulse); end
        for (int i = 0; i < 23; i++) send_gen(1'b0);
        checks += 2;
        if (locked !== 1'b0) begin failures++; $display("FAIL burst_early_relock got=%0b exp=0", locked); end
        if (bit_count !== 32'd16) begin failures++; $display("FAIL burst_hunt_count got=%0d exp=16", bit_count); end
        send_gen(1'b0);
        checks++;
        if (locked !== 1'b1) begin failures++; $display("FAIL burst_relock_24 got=%0b exp=1", locked); end
        $display("test_burst done err_count=%0d", err_count);
    endtask

    task automatic test_zero_stream();
        int lock_seen = 0;
        apply_reset();
        for (int i = 0; i < 200; i++) begin
            send_bit(1'b0, 1'b0);
            if (locked !== 1'b0) lock_seen++;
        end
        checks += 3;
        if (lock_seen != 0) begin failures++; $display("FAIL zero_locked cycles=%0d exp=0", lock_seen); end
        if (bit_count !== 32'd0) begin failures++; $display("FAIL zero_bit_count got=%0d exp=0", bit_count); end
        if (err_count !== 32'd0) begin failures++; $display("FAIL zero_err_count got=%0d exp=0", err_count); end
        $display("test_zero_stream done");
    endtask

    task automatic test_clear();
        logic b;
        lock_up();
        for (int i = 0; i < 10; i++) send_gen(1'b0);
        checks++;
        if (bit_count !== 32'd10) begin failures++; $display("FAIL clear_pre_count got=%0d exp=10", bit_count); end
        gen_next(b);
        send_bit(~b, 1'b1);
        checks += 4;
        if (bit_count !== 32'd0) begin failures++; $display("FAIL clear_bit_count got=%0d exp=0", bit_count); end
        if (err_count !== 32'd0) begin failures++; $display("FAIL clear_err_count got=%0d exp=0", err_count); end
        if (locked !== 1'b1) begin failures++; $display("FAIL clear_locked got=%0b exp=1", locked); end
        if (err_pulse !== 1'b1) begin failures++; $display("FAIL clear_err_pulse got=%0b exp=1", err_pulse); end
        send_gen(1'b0);
        checks += 2;
        if (bit_count !== 32'd1) begin failures++; $display("FAIL clear_resume_bits got=%0d exp=1", bit_count); end
        if (err_count !== 32'd0) begin failures++; $display("FAIL clear_resume_errs got=%0d exp=0", err_count); end
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        checks++;
        if (bit_count !== 32'd0) begin failures++; $display("FAIL clear_idle got=%0d exp=0", bit_count); end
        $display("test_clear done");
    endtask

    task automatic test_async_reset();
        lock_up();
        for (int i = 0; i < 5; i++) send_gen(1'b0);
        send_gen(1'b1);
        checks++;
        if (err_pulse !== 1'b1) begin failures++; $display("FAIL areset_pre_pulse got=%0b exp=1", err_pulse); end
        #2;
        reset = 1'b0;
        #1;
        checks += 4;
        if (locked !== 1'b0) begin failures++; $display("FAIL areset_locked got=%0b exp=0", locked); end
        if (err_pulse !== 1'b0) begin failures++; $display("FAIL areset_err_pulse got=%0b exp=0", err_pulse); end
        if (bit_count !== 32'd0) begin failures++; $display("FAIL areset_bit_count got=%0d exp=0", bit_count); end
        if (err_count !== 32'd0) begin failures++; $display("FAIL areset_err_count got=%0d exp=0", err_count); end
        @(posedge clock);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 23; i++) send_gen(1'b0);
        checks++;
        if (locked !== 1'b0) begin failures++; $display("FAIL areset_early_relock got=%0b exp=0", locked); end
        send_gen(1'b0);
        checks++;
        if (locked !== 1'b1) begin failures++; $display("FAIL areset_relock_24 got=%0b exp=1", locked); end
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_gapped();
        test_sparse_errors();
        test_burst();
        test_zero_stream();
        test_clear();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 16, meaning consecutive correct predictions required to declare lock.
REQ-002 SHALL have parameter LOSS_WIN, default 64, meaning length in valid bits of the loss-of-lock observation window.
REQ-003 SHALL have parameter LOSS_THR, default 8, meaning errors within one window that force loss of lock.
REQ-004 SHALL have port clock  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  in_bit is a received PRBS bit this cycle.
REQ-007 SHALL have port in_bit  input  1  received serial bit from the error-injected generator stream.
REQ-008 SHALL have port clear  input  1  synchronous zeroing of both statistics counters.
REQ-009 SHALL have port locked  output  1  checker is synchronised to the stream.
REQ-010 SHALL have port err_pulse  output  1  one-cycle flag: the previous valid bit mismatched while locked.
REQ-011 SHALL have port bit_count  output  32  valid bits checked while locked, saturating.
REQ-012 SHALL have port err_count  output  32  mismatched bits while locked, saturating.

Function
REQ-013 SHALL use the generator polynomial: 8-bit history h, predicted bit p = h[6]^h[5]^h[0], shift h <= {h[6:0], bit}.
REQ-014 SHALL implement two states, HUNT and LOCKED, with HUNT entered after reset.
REQ-015 SHALL change state, history and counters only in cycles with in_valid=1; idle cycles hold everything except err_pulse, which clears.
REQ-016 In HUNT, SHALL shift in_bit into h on every valid bit; the first 8 valid bits after entering HUNT only fill h (fill counter 0..8).
REQ-017 In HUNT with h filled, SHALL increment match_cnt when in_bit==p and reset it to 0 when in_bit!=p.
REQ-018 In HUNT, SHALL hold match_cnt at 0 while h==8'h00, so that an all-zero stream never locks.
REQ-019 SHALL enter LOCKED on the valid bit that brings match_cnt to LOCK_CNT; the local LFSR is loaded with the updated h, and locked asserts from the next cycle.
REQ-020 In LOCKED, SHALL free-run the local LFSR (shift in p, never in_bit) on each valid bit and flag an error when in_bit!=p.
REQ-021 SHALL register err_pulse, bit_count and err_count one cycle after the valid bit (latency 1).
REQ-022 bit_count and err_count SHALL increment only for valid bits in LOCKED and SHALL saturate at 32'hFFFFFFFF.
REQ-023 SHALL count valid bits (win_cnt) and errors (win_err) in LOCKED; win_cnt==LOSS_WIN-1 on a valid bit restarts both at 0.
REQ-024 SHALL return to HUNT, with fill, match_cnt and the window cleared, on the valid bit where win_err plus the current error reaches LOSS_THR; that bit is still counted.
REQ-025 clear SHALL zero bit_count and err_count, override a same-cycle increment, and not affect state, h, LFSR or window.
REQ-026 Window expiry and threshold on the same bit SHALL resolve as loss of lock.

Reset
REQ-027 On reset low, SHALL immediately set state=HUNT, h=0, LFSR=0, fill=0, match_cnt=0, win_cnt=0, win_err=0.
REQ-028 On reset low, SHALL immediately set locked=0, err_pulse=0, bit_count=0, err_count=0.
REQ-029 Reset mid-stream SHALL discard lock; re-lock requires 8 fill bits plus LOCK_CNT matches.

Structure
REQ-030 Shared package bert_pkg SHALL hold PRBS width (8), tap positions (6,5,0), counter width (32) and the HUNT/LOCKED state type, shared with the generator and error injector.
REQ-031 The window/threshold logic SHALL be one sub-module, loss_monitor (inputs: valid, locked, err; output: lose_lock).

Verification
REQ-032 Clean generator stream, seed 8'h0F, in_valid constant -> locked rises after 8+16 valid bits (+1 cycle); err_count=0 and bit_count=N after N further bits.
REQ-033 While locked, invert one bit every 100 -> err_pulse once per inversion, err_count=10 after 1000 bits, locked stays 1.
REQ-034 While locked, invert 8 consecutive bits -> err_count=8, locked falls on the 8th, then re-locks after 24 clean bits.
REQ-035 All-zero input for 200 valid bits -> locked stays 0, counters stay 0.
REQ-036 Gapped in_valid (1 of 3 cycles) -> same lock point and counts as the REQ-032 run, measured in valid bits.
REQ-037 clear with an increment in the same cycle -> both counters 0 next cycle; reset low mid-lock -> all outputs 0 asynchronously.
